spi_slave_responder: RTL and testbench

SPI responder (slave) for the same single-mode link our SPI master drives: CPOL=0, data sampled on SCLK rising edge, driven on SCLK falling edge, LSB first, active-low chip select. All SPI pins are oversampled in the `clk` domain. No SCLK-clocked logic is allowed. The block shifts one transmit word out on MISO while it shifts one receive word in from MOSI, and gives the system side a valid/ready transmit port and a pulsed receive port. It sits between the pads and the peripheral register logic of a device that answers our master.

---
 rtl/spi_slave_responder.sv | 211 +++++++++++++++++++++
 tb/tb_spi_slave_responder.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_responder.sv
// spi_slave_responder
//   SPI responder for the single-mode link (CPOL=0, sample on SCLK rise,
//   drive on SCLK fall, LSB first, active-low chip select). Every SPI pin is
//   oversampled in the clk domain, so there is no SCLK-clocked logic. One
//   transmit word shifts out on MISO while one receive word shifts in.
//
// Ports
//   clk, reset    system clock, synchronous active-high reset
//   sclk, cs      SPI clock and chip select from the master (asynchronous)
//   mosi          master-out data (asynchronous)
//   miso          slave-out data, registered
//   miso_oe       MISO pad output enable, high only while a frame is active
//   tx_data       word for a future frame, taken when tx_valid && tx_ready
//   tx_valid      tx_data valid
//   tx_ready      transmit holding register empty
//   rx_data       last complete received word, held until the next one
//   rx_valid      one-cycle pulse when rx_data updates
//   tx_underrun   one-cycle pulse, frame started with no word loaded
//   frame_error   one-cycle pulse, cs released before DATA_WIDTH bits
//   busy          FSM not in IDLE
//
// state   | meaning
// IDLE    | no frame; waiting for cs low after cs has been seen high
// SHIFT   | frame active; shifting on detected sclk edges
// WAIT_CS | all bits received; ignoring sclk until cs goes high

module spi_slave_responder #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sclk,
  input  logic                  cs,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  miso_oe,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  tx_underrun,
  output logic                  frame_error,
  output logic                  busy
);

  localparam int CW = $clog2(DATA_WIDTH) + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DATA_WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, WAIT_CS} state_t;

  state_t state, state_next;

  logic sclk_meta, sclk_sync, sclk_prev;
  logic cs_meta, cs_sync, cs_armed;
  logic mosi_meta, mosi_sync;
  logic sclk_rise, sclk_fall;

  logic [DATA_WIDTH-1:0] holding;
  logic                  tx_full;
  logic [DATA_WIDTH-1:0] tx_shift;
  logic [DATA_WIDTH-1:0] rx_shift;
  logic [DATA_WIDTH-1:0] rx_shift_next;
  logic [CW-1:0]         count;
  logic [CW-1:0]         count_inc;

  logic start, abort, rx_step, tx_step, finish, release_cs;

  // cs synchroniser resets to the "selected" level and cs_armed only sets
  // on a real high, so a reset taken mid-frame never restarts on a cs that
  // is still low; a fresh high->low is required.
  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_meta <= 1'b0;
      sclk_sync <= 1'b0;
      sclk_prev <= 1'b0;
      cs_meta   <= 1'b0;
      cs_sync   <= 1'b0;
      cs_armed  <= 1'b0;
      mosi_meta <= 1'b0;
      mosi_sync <= 1'b0;
    end else begin
      sclk_meta <= sclk;
      sclk_sync <= sclk_meta;
      sclk_prev <= sclk_sync;
      cs_meta   <= cs;
      cs_sync   <= cs_meta;
      mosi_meta <= mosi;
      mosi_sync <= mosi_meta;
      if (cs_sync) cs_armed <= 1'b1;
    end
  end

  assign sclk_rise     = sclk_sync & ~sclk_prev;
  assign sclk_fall     = ~sclk_sync & sclk_prev;
  assign count_inc     = count + 1'b1;
  assign rx_shift_next = {mosi_sync, rx_shift[DATA_WIDTH-1:1]};
  assign tx_ready      = ~tx_full;
  assign busy          = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    start      = 1'b0;
    abort      = 1'b0;
    rx_step    = 1'b0;
    tx_step    = 1'b0;
    finish     = 1'b0;
    release_cs = 1'b0;
    case (state)
      IDLE: begin
        if (cs_armed && !cs_sync) begin
          start      = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        // cs release wins over any edge seen in the same cycle
        if (cs_sync) begin
          abort      = 1'b1;
          state_next = IDLE;
        end else begin
          if (sclk_rise) begin
            rx_step = 1'b1;
            if (count_inc == FULL_COUNT) begin
              finish     = 1'b1;
              state_next = WAIT_CS;
            end
          end
          // count is below DATA_WIDTH throughout SHIFT; a fall before the
          // first rise is not a bit boundary
          if (sclk_fall && count != '0) tx_step = 1'b1;
        end
      end
      WAIT_CS: begin
        if (cs_sync) begin
          release_cs = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      holding     <= '0;
      tx_full     <= 1'b0;
      tx_shift    <= '0;
      rx_shift    <= '0;
      rx_data     <= '0;
      count       <= '0;
      miso        <= 1'b0;
      miso_oe     <= 1'b0;
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
      frame_error <= 1'b0;

      // A handshake can only happen while holding is empty, so it never
      // collides with frame start consuming a full holding register.
      if (tx_valid && tx_ready) begin
        holding <= tx_data;
        tx_full <= 1'b1;
      end

      if (start) begin
        count   <= '0;
        miso_oe <= 1'b1;
        if (tx_full) begin
          tx_shift <= holding;
          miso     <= holding[0];
          tx_full  <= 1'b0;
        end else begin
          tx_shift    <= '0;
          miso        <= 1'b0;
          tx_underrun <= 1'b1;
        end
      end

      if (abort || release_cs) begin
        miso    <= 1'b0;
        miso_oe <= 1'b0;
      end

      if (abort) frame_error <= 1'b1;

      if (rx_step) begin
        rx_shift <= rx_shift_next;
        count    <= count_inc;
        if (finish) begin
          rx_data  <= rx_shift_next;
          rx_valid <= 1'b1;
        end
      end

      if (tx_step) begin
        tx_shift <= {1'b0, tx_shift[DATA_WIDTH-1:1]};
        miso     <= tx_shift[1];
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_responder.sv
// Directed bench for spi_slave_responder: a master model drives sclk at
// clk/8 (4 clk per phase), sampling miso just before each rising edge.
module tb_spi_slave_responder;

  logic       clk = 1'b0;
  logic       reset;
  logic       sclk, cs, mosi;
  logic       miso, miso_oe;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid, tx_underrun, frame_error, busy;

  int n_cmp = 0;
  int n_bad = 0;
  int n_rxv = 0;
  int n_ur  = 0;
  int n_fe  = 0;

  spi_slave_responder #(.DATA_WIDTH(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .sclk        (sclk),
    .cs          (cs),
    .mosi        (mosi),
    .miso        (miso),
    .miso_oe     (miso_oe),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .tx_underrun (tx_underrun),
    .frame_error (frame_error),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // pulse monitors: count high cycles, so a stretched pulse shows as extra
  always @(negedge clk) begin
    if (rx_valid)    n_rxv++;
    if (tx_underrun) n_ur++;
    if (frame_error) n_fe++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_word(input logic [7:0] d);
    int n;
    @(negedge clk);
    tx_data  = d;
    tx_valid = 1'b1;
    n = 0;
    while (!tx_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("load_timeout", 32'(tx_ready), 32'd1);
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  // nbits rising edges; optional handshake placed in the frame-start cycle
  task automatic spi_frame(input logic [7:0] mw, input int nbits, input bit hs,
                           input logic [7:0] hw, input bit rel, output logic [7:0] sw);
    sw = 8'h00;
    @(negedge clk);
    cs   = 1'b0;
    mosi = mw[0];
    @(negedge clk);
    @(negedge clk);
    if (hs) begin
      tx_data  = hw;
      tx_valid = 1'b1;
    end
    @(negedge clk);
    if (hs) tx_valid = 1'b0;
    @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      if (i == 0) check("miso_oe_active", 32'(miso_oe), 32'd1);
      sw[i] = miso;
      sclk  = 1'b1;
      repeat (4) @(negedge clk);
      sclk = 1'b0;
      if (i + 1 < 8) mosi = mw[i+1];
      repeat (4) @(negedge clk);
    end
    if (rel) begin
      cs = 1'b1;
      repeat (2) @(negedge clk);
    end
  endtask

  initial begin
    logic [7:0] sw;
    int rxv0, ur0, fe0;

    reset = 1'b1; sclk = 1'b0; cs = 1'b1; mosi = 1'b0;
    tx_data = 8'h00; tx_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_miso",    32'(miso), 32'd0);
    check("rst_miso_oe", 32'(miso_oe), 32'd0);
    check("rst_tx_ready", 32'(tx_ready), 32'd1);
    check("rst_rx_data", 32'(rx_data), 32'h00);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_underrun", 32'(tx_underrun), 32'd0);
    check("rst_frame_err", 32'(frame_error), 32'd0);
    check("rst_busy",    32'(busy), 32'd0);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    // basic frame
    load_word(8'hA5);
    check("basic_ready_before", 32'(tx_ready), 32'd0);
    rxv0 = n_rxv; ur0 = n_ur;
    spi_frame(8'h3C, 8, 1'b0, 8'h00, 1'b1, sw);
    repeat (3) @(negedge clk);
    check("basic_miso_word", 32'(sw), 32'hA5);
    check("basic_rx_data", 32'(rx_data), 32'h3C);
    check("basic_rx_pulses", 32'(n_rxv - rxv0), 32'd1);
    check("basic_no_underrun", 32'(n_ur - ur0), 32'd0);
    check("basic_ready_after", 32'(tx_ready), 32'd1);
    check("basic_idle_oe", 32'(miso_oe), 32'd0);
    check("basic_idle_busy", 32'(busy), 32'd0);

    // underrun
    rxv0 = n_rxv; ur0 = n_ur;
    spi_frame(8'hFF, 8, 1'b0, 8'h00, 1'b1, sw);
    repeat (3) @(negedge clk);
    check("ur_miso_word", 32'(sw), 32'h00);
    check("ur_pulses", 32'(n_ur - ur0), 32'd1);
    check("ur_rx_data", 32'(rx_data), 32'hFF);
    check("ur_rx_pulses", 32'(n_rxv - rxv0), 32'd1);

    // abort after 5 bits, then a full frame
    rxv0 = n_rxv; fe0 = n_fe;
    spi_frame(8'h96, 5, 1'b0, 8'h00, 1'b1, sw);
    repeat (3) @(negedge clk);
    check("abort_fe_pulses", 32'(n_fe - fe0), 32'd1);
    check("abort_no_rx_valid", 32'(n_rxv - rxv0), 32'd0);
    check("abort_rx_held", 32'(rx_data), 32'hFF);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_oe", 32'(miso_oe), 32'd0);
    spi_frame(8'h81, 8, 1'b0, 8'h00, 1'b1, sw);
    repeat (3) @(negedge clk);
    check("after_abort_rx", 32'(rx_data), 32'h81);
    check("after_abort_pulses", 32'(n_rxv - rxv0), 32'd1);
    check("after_abort_no_fe", 32'(n_fe - fe0), 32'd1);

    // back-to-back, cs high 3 clk between frames
    load_word(8'h01);
    rxv0 = n_rxv; ur0 = n_ur;
    fork
      spi_frame(8'h10, 8, 1'b0, 8'h00, 1'b1, sw);
      load_word(8'h02);
    join
    check("b2b_word1", 32'(sw), 32'h01);
    fork
      spi_frame(8'h20, 8, 1'b0, 8'h00, 1'b1, sw);
      load_word(8'h03);
    join
    check("b2b_word2", 32'(sw), 32'h02);
    spi_frame(8'h30, 8, 1'b0, 8'h00, 1'b1, sw);
    check("b2b_word3", 32'(sw), 32'h03);
    repeat (3) @(negedge clk);
    check("b2b_rx_pulses", 32'(n_rxv - rxv0), 32'd3);
    check("b2b_no_underrun", 32'(n_ur - ur0), 32'd0);
    check("b2b_rx_last", 32'(rx_data), 32'h30);

    // handshake in the frame-start cycle with holding empty
    ur0 = n_ur;
    spi_frame(8'h6B, 8, 1'b1, 8'h5A, 1'b1, sw);
    repeat (3) @(negedge clk);
    check("hs_miso_word", 32'(sw), 32'h00);
    check("hs_underrun", 32'(n_ur - ur0), 32'd1);
    check("hs_holding_full", 32'(tx_ready), 32'd0);
    check("hs_rx_data", 32'(rx_data), 32'h6B);
    ur0 = n_ur;
    spi_frame(8'h00, 8, 1'b0, 8'h00, 1'b1, sw);
    repeat (3) @(negedge clk);
    check("hs_next_word", 32'(sw), 32'h5A);
    check("hs_next_no_ur", 32'(n_ur - ur0), 32'd0);

    // reset mid-frame after 3 bits
    load_word(8'h33);
    rxv0 = n_rxv; ur0 = n_ur; fe0 = n_fe;
    spi_frame(8'hE7, 3, 1'b0, 8'h00, 1'b0, sw);
    check("rstmid_partial_bits", 32'(sw[2:0]), 32'h3);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rstmid_miso", 32'(miso), 32'd0);
    check("rstmid_oe", 32'(miso_oe), 32'd0);
    check("rstmid_ready", 32'(tx_ready), 32'd1);
    check("rstmid_rx_data", 32'(rx_data), 32'h00);
    check("rstmid_busy", 32'(busy), 32'd0);
    repeat (10) @(negedge clk);
    check("rstmid_no_restart", 32'(busy), 32'd0);
    check("rstmid_no_pulses", 32'((n_rxv - rxv0) + (n_ur - ur0) + (n_fe - fe0)), 32'd0);
    cs = 1'b1;
    repeat (4) @(negedge clk);
    load_word(8'hC3);
    rxv0 = n_rxv;
    spi_frame(8'h5E, 8, 1'b0, 8'h00, 1'b1, sw);
    repeat (3) @(negedge clk);
    check("rstmid_after_word", 32'(sw), 32'hC3);
    check("rstmid_after_rx", 32'(rx_data), 32'h5E);
    check("rstmid_after_pulses", 32'(n_rxv - rxv0), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
